// File: rtl/cpu_run_controller_if.sv
// rtl/cpu_run_controller_if.sv - control, breakpoint and status bundle between board/core and the run controller
interface cpu_run_controller_if #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
);
    logic             run_req;
    logic             halt_req;
    logic             step_req;
    logic             bp_valid;
    logic [PC_W-1:0]  bp_addr;
    logic [PC_W-1:0]  pc;
    logic             branch;
    logic             cpu_en;
    logic [1:0]       state;
    logic             halted;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] branch_count;

    modport master (
        output run_req, halt_req, step_req, bp_valid, bp_addr, pc, branch,
        input  cpu_en, state, halted, instr_count, branch_count
    );

    modport slave (
        input  run_req, halt_req, step_req, bp_valid, bp_addr, pc, branch,
        output cpu_en, state, halted, instr_count, branch_count
    );
endinterface

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - run/step/halt sequencer issuing divided cpu_en ticks with PC breakpoint
// Optional macro CPU_BRANCH_TRACE_EN enables the taken-branch counter.
module cpu_run_controller #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16,
    parameter int DIV   = 4
) (
    input  logic              clk_in,
    input  logic              reset,
    cpu_run_controller_if.slave bus
);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_BREAK = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_cpu_en;
    logic               w_en_next;
    logic               r_skip_bp;
    logic               w_skip_next;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [CNT_W-1:0]   r_instr_count;
    logic               w_tick;
    logic               w_bp_hit;

    assign w_tick   = (r_div_cnt == DIV_W'(DIV - 1));
    assign w_bp_hit = bus.bp_valid & (bus.pc == bus.bp_addr) & ~r_skip_bp;

    // Free-running divider; mode changes never disturb its phase.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cpu_en  <= 1'b0;
            r_skip_bp <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cpu_en  <= w_en_next;
            r_skip_bp <= w_skip_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_en_next    = 1'b0;
        w_skip_next  = r_skip_bp;
        if (bus.halt_req) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.step_req) begin
                        w_state_next = S_STEP;
                    end else if (bus.run_req) begin
                        w_state_next = S_RUN;
                    end
                end
                // Leaving a breakpoint arms skip_bp so the stopped instruction itself executes.
                S_BREAK: begin
                    if (bus.step_req) begin
                        w_state_next = S_STEP;
                        w_skip_next  = 1'b1;
                    end else if (bus.run_req) begin
                        w_state_next = S_RUN;
                        w_skip_next  = 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_tick) begin
                        if (w_bp_hit) begin
                            w_state_next = S_BREAK;
                        end else begin
                            w_en_next = 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    if (w_tick) begin
                        w_state_next = S_IDLE;
                        w_en_next    = 1'b1;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
        if (w_en_next) begin
            w_skip_next = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_instr_count <= '0;
        end else if (r_cpu_en && (r_instr_count != {CNT_W{1'b1}})) begin
            r_instr_count <= r_instr_count + 1'b1;
        end
    end

`ifdef CPU_BRANCH_TRACE_EN
    logic [CNT_W-1:0] r_branch_count;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_branch_count <= '0;
        end else if (r_cpu_en && bus.branch && (r_branch_count != {CNT_W{1'b1}})) begin
            r_branch_count <= r_branch_count + 1'b1;
        end
    end

    assign bus.branch_count = r_branch_count;
`else
    logic w_unused_branch;

    assign w_unused_branch  = bus.branch;
    assign bus.branch_count = '0;
`endif

    assign bus.cpu_en      = r_cpu_en;
    assign bus.state       = r_state;
    assign bus.halted      = (r_state == S_IDLE) || (r_state == S_BREAK);
    assign bus.instr_count = r_instr_count;
endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - scoreboard bench: expected pulses queued by stimulus, checked by a cpu_en monitor
module tb_cpu_run_controller;
    localparam int DIV = 4;
`ifdef CPU_BRANCH_TRACE_EN
    localparam int EXP_BR = 3;
`else
    localparam int EXP_BR = 0;
`endif

    typedef struct {
        int pc;
        int gap;
    } exp_t;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] core_pc = 8'd0;
    exp_t       exp_q[$];
    int         n_total = 0;
    int         n_pass  = 0;
    int         cyc     = 0;
    int         last_cyc = 0;

    cpu_run_controller_if #(.PC_W(8), .CNT_W(16)) bus ();

    cpu_run_controller #(.PC_W(8), .CNT_W(16), .DIV(DIV)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;
    assign bus.pc = core_pc;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: core model advances pc on each execute pulse and scores it against the queue.
    always @(negedge clk_in) begin
        if (reset) begin
            core_pc = 8'd0;
        end else if (bus.cpu_en) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_cpu_en: got pulse at pc %0d expected none", core_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_pc", int'(core_pc), e.pc);
                if (e.gap != 0) check("pulse_gap", cyc - last_cyc, e.gap);
            end
            last_cyc = cyc;
            core_pc  = core_pc + 8'd1;
        end
    end

    task automatic push_run(input int first_pc, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc  = first_pc + i;
            e.gap = (i == 0) ? 0 : DIV;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_pulse(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (bus.cpu_en) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_total++;
            $display("FAIL %s: got no cpu_en within 20 cycles expected a pulse", name);
        end
    endtask

    task automatic pulse_run();
        @(negedge clk_in) bus.run_req = 1'b1;
        @(negedge clk_in) bus.run_req = 1'b0;
    endtask

    task automatic pulse_step();
        @(negedge clk_in) bus.step_req = 1'b1;
        @(negedge clk_in) bus.step_req = 1'b0;
    endtask

    task automatic do_halt();
        bus.halt_req = 1'b1;
        @(negedge clk_in) bus.halt_req = 1'b0;
    endtask

    initial begin
        int lat;
        bit seen;
        bus.run_req  = 1'b0;
        bus.halt_req = 1'b0;
        bus.step_req = 1'b0;
        bus.bp_valid = 1'b0;
        bus.bp_addr  = 8'h05;
        bus.branch   = 1'b0;

        #100;
        check("reset_state", int'(bus.state), 0);
        check("reset_cpu_en", int'(bus.cpu_en), 0);
        check("reset_halted", int'(bus.halted), 1);
        check("reset_instr_count", int'(bus.instr_count), 0);
        check("reset_branch_count", int'(bus.branch_count), 0);
        reset = 1'b0;

        // Free run: ten pulses spaced DIV cycles apart.
        push_run(0, 10);
        pulse_run();
        check("run_state", int'(bus.state), 1);
        for (int i = 0; i < 10; i++) wait_pulse("run_pulse");
        do_halt();
        check("halt_state", int'(bus.state), 0);
        check("halt_halted", int'(bus.halted), 1);
        repeat (2) @(negedge clk_in);
        check("run_instr_count", int'(bus.instr_count), 10);

        repeat (3) @(negedge clk_in) reset = 1'b1;
        @(negedge clk_in) reset = 1'b0;

        // Breakpoint at pc 5.
        bus.bp_valid = 1'b1;
        push_run(0, 5);
        pulse_run();
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_in);
            if (bus.state == 2'd3) begin
                seen = 1'b1;
                break;
            end
        end
        check("break_reached", int'(seen), 1);
        check("break_halted", int'(bus.halted), 1);
        check("break_instr_count", int'(bus.instr_count), 5);
        repeat (8) @(negedge clk_in);
        check("break_holds", int'(bus.state), 3);

        // Resume executes pc 5 without re-breaking, then pc 6.
        push_run(5, 2);
        pulse_run();
        wait_pulse("resume_pc5");
        wait_pulse("resume_pc6");
        do_halt();
        check("resume_halt_state", int'(bus.state), 0);
        repeat (2) @(negedge clk_in);
        check("resume_instr_count", int'(bus.instr_count), 7);

        // Single step from IDLE.
        push_run(7, 1);
        pulse_step();
        lat = 0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk_in);
            if (bus.cpu_en) begin
                lat = j;
                break;
            end
        end
        check("step_latency_ok", int'(lat >= 1 && lat <= DIV), 1);
        repeat (8) @(negedge clk_in);
        check("step_state", int'(bus.state), 0);
        check("step_instr_count", int'(bus.instr_count), 8);

        // step_req in RUN ignored; then run+halt together on a tick edge.
        push_run(8, 3);
        pulse_run();
        wait_pulse("run2_pc8");
        pulse_step();
        wait_pulse("run2_pc9");
        wait_pulse("run2_pc10");
        repeat (3) @(negedge clk_in);
        bus.run_req  = 1'b1;
        bus.halt_req = 1'b1;
        @(negedge clk_in);
        bus.run_req  = 1'b0;
        bus.halt_req = 1'b0;
        check("run_halt_state", int'(bus.state), 0);
        repeat (6) @(negedge clk_in);
        check("run2_instr_count", int'(bus.instr_count), 11);

        // Three taken branches, then async reset while cpu_en is high.
        bus.branch = 1'b1;
        push_run(11, 4);
        pulse_run();
        for (int i = 0; i < 3; i++) wait_pulse("branch_pulse");
        @(negedge clk_in) bus.branch = 1'b0;
        check("branch_count", int'(bus.branch_count), EXP_BR);
        wait_pulse("pre_reset_pulse");
        #2 reset = 1'b1;
        #1;
        check("async_cpu_en", int'(bus.cpu_en), 0);
        check("async_instr_count", int'(bus.instr_count), 0);
        check("async_branch_count", int'(bus.branch_count), 0);
        check("async_state", int'(bus.state), 0);
        check("async_halted", int'(bus.halted), 1);
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        repeat (10) @(negedge clk_in);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Run/step/halt sequencer for the microprocessor core. Generates a single-cycle execute enable (cpu_en) derived from clk_in through a programmable divider. Supports free-run, single-step and PC-match breakpoint, and keeps executed-instruction statistics for the seven-segment debug display. Sits between the board clock/buttons and the core's clock-enable input, and watches the core's fetch address (read_address).

Parameters:
PC_W, 8, width of the program counter / IMEM read address
CNT_W, 16, width of the instruction and branch counters
DIV, 4, number of clk_in cycles per execute tick; legal values are 1 and above

Ports:
clk_in  input  1  system clock
reset  input  1  asynchronous, active-high reset
run_req  input  1  level or pulse; request free-run
halt_req  input  1  level or pulse; request halt (highest priority)
step_req  input  1  single-cycle pulse; execute exactly one instruction
bp_valid  input  1  breakpoint armed
bp_addr  input  PC_W  breakpoint address
pc  input  PC_W  core fetch address (read_address)
branch  input  1  core branch-taken flag for the current instruction
cpu_en  output  1  registered; one-cycle execute enable to the core
state  output  2  0=IDLE, 1=RUN, 2=STEP, 3=BREAK
halted  output  1  high when state is IDLE or BREAK
instr_count  output  CNT_W  number of cpu_en pulses issued; saturating
branch_count  output  CNT_W  number of taken branches; saturating (see Optional Feature)

Behaviour:
- Reset (async):
  - state=IDLE, cpu_en=0, halted=1.
  - div_cnt=0, instr_count=0, branch_count=0, skip_bp=0.
- Divider:
  - div_cnt is free-running: 0..DIV-1, wraps to 0.
  - tick is combinational: div_cnt==DIV-1. With DIV=1, tick is always high.
  - Mode changes never reset div_cnt.
- Breakpoint hit: bp_hit = bp_valid & (pc==bp_addr) & ~skip_bp.
- Next-state priority at each edge: halt_req > step_req > run_req > tick-driven transition.
- State transitions:
  - Any state with halt_req → IDLE; cpu_en_next=0.
  - IDLE with step_req → STEP.
  - IDLE with run_req → RUN.
  - BREAK with step_req → STEP; skip_bp is set.
  - BREAK with run_req → RUN; skip_bp is set.
  - RUN with tick & bp_hit → BREAK; cpu_en_next=0.
  - RUN with tick & ~bp_hit → stay in RUN; cpu_en_next=1.
  - STEP with tick → IDLE; cpu_en_next=1. The breakpoint is ignored in STEP.
  - step_req while in RUN or STEP is ignored. run_req while in RUN or STEP is ignored.
- skip_bp is cleared on the edge that issues a cpu_en pulse. This guarantees resume/step from a breakpoint executes the breakpoint instruction itself.
- cpu_en:
  - Registered; high for exactly one clk_in cycle per issued instruction.
  - Never high on two consecutive cycles unless DIV=1 and state stays RUN.
- Step latency: cpu_en rises 1..DIV cycles after the step_req edge.
- instr_count: +1 on each cycle in which cpu_en=1; holds at 2^CNT_W-1.
- A reset asserted mid-run aborts immediately; the outputs take their reset values asynchronously.
- The pc input is sampled only on tick edges; its value between ticks is don't-care.

Optional Feature:
CPU_BRANCH_TRACE_EN
- Defined: branch_count increments (saturating) on each cycle where cpu_en=1 and branch=1.
- Undefined: branch_count is constant 0 and the counter logic is not synthesized.
- The port list is identical in both builds.

Test Plan:
- DIV=4, reset for 100 ns, release, then pulse run_req:
  - state=1.
  - cpu_en pulses every 4 cycles.
  - After 10 ticks, instr_count=10.
- RUN with bp_valid=1, bp_addr=8'h05, pc stepping 0,1,2…:
  - On the tick where pc=5: no cpu_en, state=3, halted=1.
  - instr_count=5.
- From BREAK at pc=5, pulse run_req:
  - The next tick issues cpu_en with pc=5, no re-break.
  - Execution continues to pc=6.
- From IDLE, pulse step_req:
  - Exactly one cpu_en within 4 cycles; state returns to 0; instr_count=+1.
  - A step_req pulsed while in RUN causes no extra cpu_en.
- Simultaneous run_req=1 and halt_req=1 in RUN → state=0 and no cpu_en on that tick.
- Reset asserted in RUN between ticks:
  - cpu_en=0 and counters=0 immediately.
  - With CPU_BRANCH_TRACE_EN, 3 taken branches before reset give branch_count=3; without the macro, branch_count stays 0.
